// File: rtl/direction_stepper.sv
// direction_stepper: player movement controller. Latches a committed direction
// plus a one-deep pending turn from debounced buttons, runs its own move tick,
// and moves the player position with clamp or wrap at the playfield edges.
module direction_stepper #(
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int X_START       = 320,
  parameter int Y_START       = 240,
  parameter int STEP_DIV      = 500000,
  parameter int DIV_W         = 20,
  parameter int WRAP          = 0,
  parameter int ALLOW_REVERSE = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic           halt,
  output logic [3:0]     dir,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           step,
  output logic           wall_hit
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_HALTED} state_t;

  localparam logic [3:0] D_UP = 4'b1000, D_DN = 4'b0100,
                         D_LT = 4'b0010, D_RT = 4'b0001;

  state_t         state_q, state_d;
  logic [3:0]     dir_q, dir_d;
  logic [3:0]     pend_q, pend_d;   // 0000 means no turn queued
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           step_q, step_d;
  logic           wall_q, wall_d;

  logic [3:0] req, opp, mdir;
  logic       req_ok, tick;

  // Request decode, validity against the current committed direction
  always_comb begin
    if (up)         req = D_UP;
    else if (down)  req = D_DN;
    else if (left)  req = D_LT;
    else if (right) req = D_RT;
    else            req = 4'b0000;
    opp    = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    req_ok = (req != 4'b0000) && (req != dir_q) &&
             ((ALLOW_REVERSE != 0) || (req != opp));
    tick   = (cnt_q == DIV_W'(STEP_DIV - 1));
    // A queued turn takes effect on the tick that consumes it
    mdir   = (pend_q != 4'b0000) ? pend_q : dir_q;
  end

  // Next-state: halt override, idle start, tick-driven movement
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    step_d  = 1'b0;
    wall_d  = 1'b0;
    if (halt) begin
      state_d = S_HALTED;
      dir_d   = 4'b0000;
      pend_d  = 4'b0000;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_HALTED: state_d = S_IDLE;
        S_IDLE: begin
          if (req_ok) begin
            state_d = S_MOVE;
            dir_d   = req;
            cnt_d   = '0;
          end
        end
        S_MOVE: begin
          if (tick) begin
            cnt_d  = '0;
            dir_d  = mdir;
            pend_d = 4'b0000;
            // Edge comparisons before arithmetic: X_MAX may sit below 2^X_W-1
            case (mdir)
              D_UP: begin
                if (y_q != '0)                   begin y_d = y_q - Y_W'(1); step_d = 1'b1; end
                else if (WRAP != 0)              begin y_d = Y_W'(Y_MAX);   step_d = 1'b1; end
                else                             wall_d = 1'b1;
              end
              D_DN: begin
                if (y_q != Y_W'(Y_MAX))          begin y_d = y_q + Y_W'(1); step_d = 1'b1; end
                else if (WRAP != 0)              begin y_d = '0;            step_d = 1'b1; end
                else                             wall_d = 1'b1;
              end
              D_LT: begin
                if (x_q != '0)                   begin x_d = x_q - X_W'(1); step_d = 1'b1; end
                else if (WRAP != 0)              begin x_d = X_W'(X_MAX);   step_d = 1'b1; end
                else                             wall_d = 1'b1;
              end
              D_RT: begin
                if (x_q != X_W'(X_MAX))          begin x_d = x_q + X_W'(1); step_d = 1'b1; end
                else if (WRAP != 0)              begin x_d = '0;            step_d = 1'b1; end
                else                             wall_d = 1'b1;
              end
              default: ;
            endcase
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // Checked against the pre-tick direction; survives to the next tick
          if (req_ok) pend_d = req;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers, asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= 4'b0000;
      pend_q  <= 4'b0000;
      cnt_q   <= '0;
      x_q     <= X_W'(X_START);
      y_q     <= Y_W'(Y_START);
      step_q  <= 1'b0;
      wall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      step_q  <= step_d;
      wall_q  <= wall_d;
    end
  end

  assign dir      = dir_q;
  assign pos_x    = x_q;
  assign pos_y    = y_q;
  assign step     = step_q;
  assign wall_hit = wall_q;

endmodule

// File: tb/tb_direction_stepper.sv
// Bench for direction_stepper: four instances sharing the button inputs
// (plain, reverse allowed, clamp near right edge, wrap near right edge),
// an integer-coordinate model per instance and directed literal checks.
module tb_direction_stepper;

  logic clk = 1'b0;
  logic reset, up, down, left, right, halt;
  logic [3:0] dir_w [4];
  logic [9:0] x_w [4];
  logic [9:0] y_w [4];
  logic       stp_w [4];
  logic       wl_w [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  direction_stepper #(.STEP_DIV(4), .DIV_W(3)) u0 (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .halt(halt), .dir(dir_w[0]), .pos_x(x_w[0]), .pos_y(y_w[0]),
    .step(stp_w[0]), .wall_hit(wl_w[0]));
  direction_stepper #(.STEP_DIV(4), .DIV_W(3), .ALLOW_REVERSE(1)) u1 (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .halt(halt), .dir(dir_w[1]), .pos_x(x_w[1]), .pos_y(y_w[1]),
    .step(stp_w[1]), .wall_hit(wl_w[1]));
  direction_stepper #(.STEP_DIV(4), .DIV_W(3), .X_START(638), .WRAP(0)) u2 (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .halt(halt), .dir(dir_w[2]), .pos_x(x_w[2]), .pos_y(y_w[2]),
    .step(stp_w[2]), .wall_hit(wl_w[2]));
  direction_stepper #(.STEP_DIV(4), .DIV_W(3), .X_START(638), .WRAP(1)) u3 (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .halt(halt), .dir(dir_w[3]), .pos_x(x_w[3]), .pos_y(y_w[3]),
    .step(stp_w[3]), .wall_hit(wl_w[3]));

  // ---------------- model ----------------
  // Directions: 0 none, 1 up, 2 down, 3 left, 4 right. Mode: 0 idle, 1 moving, 2 halted.
  typedef struct {
    int mode, d, p, phase, x, y;
    bit stp, w;
  } mst_t;

  mst_t m [4];

  function automatic int p_xs(int i);   return (i >= 2) ? 638 : 320; endfunction
  function automatic bit p_wrap(int i); return i == 3; endfunction
  function automatic bit p_rev(int i);  return i == 1; endfunction

  function automatic int opp(int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int onehot(int d);
    case (d)
      1: return 8;
      2: return 4;
      3: return 2;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic mst_t rst_val(int i);
    mst_t s;
    s.mode = 0; s.d = 0; s.p = 0; s.phase = 0;
    s.x = p_xs(i); s.y = 240; s.stp = 0; s.w = 0;
    return s;
  endfunction

  function automatic mst_t nxt(mst_t s, int i, bit u, bit dn, bit l, bit r, bit h);
    mst_t n = s;
    int rq, nx, ny, dx, dy;
    bit ok;
    n.stp = 0; n.w = 0;
    if (h) begin
      n.mode = 2; n.d = 0; n.p = 0; n.phase = 0;
      return n;
    end
    rq = u ? 1 : dn ? 2 : l ? 3 : r ? 4 : 0;
    ok = (rq != 0) && (rq != s.d) && (p_rev(i) || s.d == 0 || rq != opp(s.d));
    if (s.mode == 2) n.mode = 0;
    else if (s.mode == 0) begin
      if (ok) begin n.mode = 1; n.d = rq; n.phase = 0; end
    end else begin
      if (s.phase == 3) begin
        n.phase = 0;
        if (s.p != 0) begin n.d = s.p; n.p = 0; end
        dx = (n.d == 4) ? 1 : (n.d == 3) ? -1 : 0;
        dy = (n.d == 2) ? 1 : (n.d == 1) ? -1 : 0;
        nx = s.x + dx; ny = s.y + dy;
        if (p_wrap(i)) begin
          n.x = (nx + 640) % 640; n.y = (ny + 480) % 480; n.stp = 1;
        end else if (nx >= 0 && nx <= 639 && ny >= 0 && ny <= 479) begin
          n.x = nx; n.y = ny; n.stp = 1;
        end else n.w = 1;
      end else n.phase = s.phase + 1;
      if (ok) n.p = rq;
    end
    return n;
  endfunction

  // Model advance on the same edges as the DUTs
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) m[i] <= rst_val(i);
      else       m[i] <= nxt(m[i], i, up, down, left, right, halt);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if ($time > 20) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("m%0d_dir", i), int'(dir_w[i]), onehot(m[i].d));
        chk($sformatf("m%0d_x", i), int'(x_w[i]), m[i].x);
        chk($sformatf("m%0d_y", i), int'(y_w[i]), m[i].y);
        chk($sformatf("m%0d_step", i), int'(stp_w[i]), int'(m[i].stp));
        chk($sformatf("m%0d_wall", i), int'(wl_w[i]), int'(m[i].w));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; up = 0; down = 0; left = 0; right = 0; halt = 0;
    repeat (3) @(negedge clk);
    chk("rst_dir", int'(dir_w[0]), 0);
    chk("rst_x", int'(x_w[0]), 320);
    chk("rst_y", int'(y_w[0]), 240);
    chk("rst_x2", int'(x_w[2]), 638);
    reset = 1'b0;
    @(negedge clk);

    // right for one cycle: load, then a move every 4 edges
    right = 1; @(negedge clk); right = 0;
    chk("load_dir", int'(dir_w[0]), 4'b0001);
    chk("load_x", int'(x_w[0]), 320);
    chk("load_step", int'(stp_w[0]), 0);
    repeat (3) @(negedge clk);
    chk("pre_tick_x", int'(x_w[0]), 320);
    @(negedge clk);
    chk("tick1_x", int'(x_w[0]), 321);
    chk("tick1_step", int'(stp_w[0]), 1);
    chk("tick1_x_clamp", int'(x_w[2]), 639);
    chk("tick1_x_wrap", int'(x_w[3]), 639);
    repeat (4) @(negedge clk);
    chk("tick2_x", int'(x_w[0]), 322);
    chk("tick2_clamp_x", int'(x_w[2]), 639);
    chk("tick2_clamp_wall", int'(wl_w[2]), 1);
    chk("tick2_clamp_step", int'(stp_w[2]), 0);
    chk("tick2_wrap_x", int'(x_w[3]), 0);
    chk("tick2_wrap_step", int'(stp_w[3]), 1);
    repeat (4) @(negedge clk);
    chk("tick3_x", int'(x_w[0]), 323);
    chk("tick3_y", int'(y_w[0]), 240);
    chk("tick3_clamp_wall", int'(wl_w[2]), 1);

    // reverse request: ignored unless reversal allowed
    left = 1; @(negedge clk); left = 0;
    repeat (3) @(negedge clk);
    chk("norev_dir", int'(dir_w[0]), 4'b0001);
    chk("norev_x", int'(x_w[0]), 324);
    chk("rev_dir", int'(dir_w[1]), 4'b0010);
    chk("rev_x", int'(x_w[1]), 322);

    // later request overwrites pending
    up = 1; @(negedge clk); up = 0; down = 1; @(negedge clk); down = 0;
    repeat (2) @(negedge clk);
    chk("ovr_dir", int'(dir_w[0]), 4'b0100);
    chk("ovr_y", int'(y_w[0]), 241);
    chk("ovr_x", int'(x_w[0]), 324);

    // halt mid-period
    @(negedge clk);
    halt = 1; @(negedge clk); halt = 0;
    chk("halt_dir", int'(dir_w[0]), 0);
    chk("halt_y", int'(y_w[0]), 241);
    chk("halt_step", int'(stp_w[0]), 0);
    repeat (6) @(negedge clk);
    chk("idle_dir", int'(dir_w[0]), 0);
    chk("idle_y", int'(y_w[0]), 241);

    // up and down together: up wins
    up = 1; down = 1; @(negedge clk); up = 0; down = 0;
    chk("prio_dir", int'(dir_w[0]), 4'b1000);
    repeat (3) @(negedge clk);
    chk("prio_pre_y", int'(y_w[0]), 241);
    @(negedge clk);
    chk("prio_y", int'(y_w[0]), 240);
    chk("prio_step", int'(stp_w[0]), 1);

    // asynchronous reset between edges, button held during reset
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    reset = 1; right = 1;
    #1;
    chk("arst_dir", int'(dir_w[0]), 0);
    chk("arst_x", int'(x_w[0]), 320);
    chk("arst_y", int'(y_w[0]), 240);
    chk("arst_step", int'(stp_w[0]), 0);
    chk("arst_wall", int'(wl_w[0]), 0);
    repeat (3) @(negedge clk);
    right = 0;
    @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    chk("post_rst_dir", int'(dir_w[0]), 0);
    chk("post_rst_x", int'(x_w[0]), 320);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
